// File: rtl/ram_arb_pkg.sv
// Shared constants for the round-robin command-RAM arbiter: RAM opcodes,
// FSM state encoding and default widths.
package ram_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 2;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned OPC_W          = 2;

  localparam logic [OPC_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [OPC_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [OPC_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [OPC_W-1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_RWAIT = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Masked round-robin grant: priority starts one past the last granted index
// and the pointer advances only when the grant is taken.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic               grant_en_i,
  output logic               grant_valid_c_o,
  output logic [IDX_W-1:0]   grant_idx_c_o
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] elig;
  int unsigned        cand;

  assign elig = req_i & ~mask_i;

  // First eligible requester scanning from ptr+1, wrapping modulo NUM_REQ.
  always_comb begin
    grant_valid_c_o = 1'b0;
    grant_idx_c_o   = '0;
    cand            = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(ptr_q) + off) % NUM_REQ;
      if (!grant_valid_c_o && elig[IDX_W'(cand)]) begin
        grant_valid_c_o = 1'b1;
        grant_idx_c_o   = IDX_W'(cand);
      end
    end
  end

  assign ptr_d = (grant_en_i && grant_valid_c_o) ? grant_idx_c_o : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Shares the single-port command RAM among NUM_REQ requesters, issuing each
// transaction atomically as address + data commands. Optional RAM_ARB_ADDR_CACHE_EN
// skips the address command when the RAM already holds the granted address.
module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CMD_WIDTH  = DATA_WIDTH + OPC_W
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic [CMD_WIDTH-1:0]          ram_din,
  output logic                          ram_rx_valid,
  input  logic [DATA_WIDTH-1:0]         ram_dout,
  input  logic                          ram_tx_valid
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d, win_idx;
  logic                   win_vld, grant_en;
  logic                   op_q, op_d, sel_op;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d, sel_addr, sel_wdata;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [CMD_WIDTH-1:0]   din_q, din_d;
  logic                   rxv_q, rxv_d, busy_q;
`ifdef RAM_ARB_ADDR_CACHE_EN
  logic [DATA_WIDTH-1:0]  la_q, la_d;
  logic                   lv_q, lv_d;
`endif

  function automatic logic [CMD_WIDTH-1:0] addr_cmd(input logic rd, input logic [DATA_WIDTH-1:0] a);
    return CMD_WIDTH'({(rd ? CMD_RD_ADDR : CMD_WR_ADDR), a});
  endfunction

  function automatic logic [CMD_WIDTH-1:0] data_cmd(input logic rd, input logic [DATA_WIDTH-1:0] d);
    return CMD_WIDTH'({(rd ? CMD_RD_DATA : CMD_WR_DATA), (rd ? DATA_WIDTH'(0) : d)});
  endfunction

  // A requester whose ack is high this cycle is masked so it cannot be re-granted at once.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clk_i           (CLK),
    .rst_ni          (rst_n),
    .req_i           (req),
    .mask_i          (ack_q),
    .grant_en_i      (grant_en),
    .grant_valid_c_o (win_vld),
    .grant_idx_c_o   (win_idx)
  );

  always_comb begin
    sel_op    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_op    = op[i];
        sel_addr  = addr[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    din_d    = din_q;
    rxv_d    = 1'b0;
    ack_d    = '0;
    grant_en = 1'b0;
`ifdef RAM_ARB_ADDR_CACHE_EN
    la_d     = la_q;
    lv_d     = lv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_en = 1'b1;
          gnt_d    = win_idx;
          op_d     = sel_op;
          wdata_d  = sel_wdata;
          rxv_d    = 1'b1;
`ifdef RAM_ARB_ADDR_CACHE_EN
          if (lv_q && (la_q == sel_addr)) begin
            din_d   = data_cmd(sel_op, sel_wdata);
            state_d = ST_DATA;
          end else begin
            din_d   = addr_cmd(sel_op, sel_addr);
            la_d    = sel_addr;
            lv_d    = 1'b1;
            state_d = ST_ADDR;
          end
`else
          din_d   = addr_cmd(sel_op, sel_addr);
          state_d = ST_ADDR;
`endif
        end
      end
      ST_ADDR: begin
        din_d   = data_cmd(op_q, wdata_q);
        rxv_d   = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (op_q) begin
          state_d = ST_RWAIT;
        end else begin
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_RWAIT: begin
        rdata_d      = ram_dout;
        ack_d[gnt_q] = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      op_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      din_q   <= '0;
      rxv_q   <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
`ifdef RAM_ARB_ADDR_CACHE_EN
      la_q    <= '0;
      lv_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      din_q   <= din_d;
      rxv_q   <= rxv_d;
      ack_q   <= ack_d;
      busy_q  <= (state_d != ST_IDLE);
`ifdef RAM_ARB_ADDR_CACHE_EN
      la_q    <= la_d;
      lv_q    <= lv_d;
`endif
    end
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign ram_din      = din_q;
  assign ram_rx_valid = rxv_q;

  // The RAM must present read data by the cycle after the read-data command.
  rwait_tx_valid_a: assert property (@(posedge CLK) disable iff (!rst_n)
    (state_q == ST_RWAIT) |-> ram_tx_valid);

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: a transaction-level schedule model predicts every
// output cycle by cycle, plus literal checks on the directed scenarios.
module tb_ram_cmd_arbiter;

  localparam int NR = 2;
`ifdef RAM_ARB_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int T1_RD_LAT = CACHE ? 3 : 4;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0, op = '0;
  logic [15:0] addr = '0, wdata = '0;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout = 8'h00;
  logic        ram_tx_valid = 1'b0;

  ram_cmd_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .CMD_WIDTH(10)) dut (
    .CLK(CLK), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .ram_din(ram_din),
    .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Command RAM: one address register shared by reads and writes, sticky tx_valid.
  logic [7:0] ram_mem [256] = '{default: 8'h00};
  logic [7:0] ram_areg = 8'h00;
  always @(posedge CLK) begin
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: ram_areg <= ram_din[7:0];
        2'b01:        ram_mem[ram_areg] <= ram_din[7:0];
        default: begin
          ram_dout     <= ram_mem[ram_areg];
          ram_tx_valid <= 1'b1;
        end
      endcase
    end
  end

  int n_vec = 0, n_err = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endfunction

  // Requester agents: hold each queued transaction until its ack, then move on.
  typedef struct { logic op; logic [7:0] addr; logic [7:0] wdata; } txn_t;
  txn_t rq[NR][$];
  logic [1:0] ack_seen = '0;

  task automatic push(int i, logic o, logic [7:0] a, logic [7:0] d);
    rq[i].push_back('{o, a, d});
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (req[i] && ack_seen[i] && rq[i].size() > 0) rq[i].delete(0);
        if (rq[i].size() > 0) begin
          req[i] = 1'b1;
          op[i] = rq[i][0].op;
          addr[i*8 +: 8] = rq[i][0].addr;
          wdata[i*8 +: 8] = rq[i][0].wdata;
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  end

  // Schedule model: future cycles are filled in when a grant is decided.
  logic       sl_busy [8], sl_rxv [8], sl_dset [8], sl_rset [8];
  logic [9:0] sl_din  [8];
  logic [1:0] sl_ack  [8];
  logic [7:0] sl_rd   [8];
  logic [7:0] m_mem [256] = '{default: 8'h00};
  logic [9:0] m_din;
  logic [7:0] m_la;
  logic       m_lv;
  int         m_free, m_ptr, cs;

  function automatic void clr(int k);
    sl_busy[k] = 0; sl_rxv[k] = 0; sl_dset[k] = 0; sl_rset[k] = 0;
    sl_din[k] = '0; sl_ack[k] = '0; sl_rd[k] = '0;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 8; k++) clr(k);
    m_din = '0; m_free = 0; m_ptr = NR - 1; m_lv = 1'b0; m_la = '0; ack_seen = '0;
  endfunction

  function automatic void m_grant(int t, int w);
    logic o;
    logic [7:0] a, d;
    int k, s;
    o = op[w]; a = addr[w*8 +: 8]; d = wdata[w*8 +: 8];
    k = 1;
    if (!(CACHE && m_lv && m_la == a)) begin
      s = (t + 1) % 8;
      sl_busy[s] = 1; sl_rxv[s] = 1; sl_dset[s] = 1; sl_din[s] = {(o ? 2'b10 : 2'b00), a};
      m_la = a; m_lv = 1'b1; k = 2;
    end
    s = (t + k) % 8;
    sl_busy[s] = 1; sl_rxv[s] = 1; sl_dset[s] = 1; sl_din[s] = {(o ? 2'b11 : 2'b01), (o ? 8'h00 : d)};
    if (o) begin
      s = (t + k + 1) % 8; sl_busy[s] = 1;
      s = (t + k + 2) % 8; sl_ack[s][w] = 1'b1; sl_rset[s] = 1; sl_rd[s] = m_mem[a];
      m_free = t + k + 2;
    end else begin
      m_mem[a] = d;
      s = (t + k + 1) % 8; sl_ack[s][w] = 1'b1;
      m_free = t + k + 1;
    end
    m_ptr = w;
  endfunction

  typedef struct { int cyc; logic [9:0] din; } cmd_ent_t;
  typedef struct { int cyc; int idx; logic [7:0] rd; } ack_ent_t;
  cmd_ent_t cmd_log[$];
  ack_ent_t ack_log[$];

  initial m_reset();

  // Compare process: every cycle, DUT outputs against the model's schedule.
  always @(negedge CLK) begin
    if (!rst_n) begin
      m_reset();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_rx_valid", 32'(ram_rx_valid), 0);
      chk("rst_din", 32'(ram_din), 0);
      chk("rst_rdata", 32'(rdata), 0);
    end else begin
      logic [1:0] elig;
      logic       found;
      int         w;
      cs = cyc % 8;
      if (sl_dset[cs]) m_din = sl_din[cs];
      chk("busy", 32'(busy), 32'(sl_busy[cs]));
      chk("ack", 32'(ack), 32'(sl_ack[cs]));
      chk("rx_valid", 32'(ram_rx_valid), 32'(sl_rxv[cs]));
      chk("din", 32'(ram_din), 32'(m_din));
      if (sl_rset[cs]) chk("rdata", 32'(rdata), 32'(sl_rd[cs]));
      ack_seen = ack;
      if (ram_rx_valid) cmd_log.push_back('{cyc, ram_din});
      if (ack != 2'b00) ack_log.push_back('{cyc, (ack[1] ? 1 : 0), rdata});
      if (cyc >= m_free) begin
        elig  = req & ~sl_ack[cs];
        found = 1'b0;
        for (int k = 1; k <= NR; k++) begin
          w = (m_ptr + k) % NR;
          if (!found && elig[w]) begin
            found = 1'b1;
            m_grant(cyc, w);
          end
        end
      end
      clr(cs);
    end
  end

  function automatic int cmd_cyc(int k); return (k < cmd_log.size()) ? cmd_log[k].cyc : -1; endfunction
  function automatic logic [9:0] cmd_din(int k); return (k < cmd_log.size()) ? cmd_log[k].din : 10'h3FF; endfunction
  function automatic int ack_cyc(int k); return (k < ack_log.size()) ? ack_log[k].cyc : -1; endfunction
  function automatic int ack_idx(int k); return (k < ack_log.size()) ? ack_log[k].idx : -1; endfunction
  function automatic logic [7:0] ack_rd(int k); return (k < ack_log.size()) ? ack_log[k].rd : 8'hXX; endfunction

  task automatic start(output int t0);
    cmd_log.delete();
    ack_log.delete();
    @(posedge CLK);
    #2;
    t0 = cyc;
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(rq[0].size() == 0 && rq[1].size() == 0 && req == 2'b00 && !busy) && n < 300);
    chk(nm, 32'(n >= 300), 0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #2; rst_n = 1'b0;
    @(posedge CLK); #2; rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    repeat (3) @(posedge CLK);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge CLK);

    // Single write then read-back from requester 0.
    push(0, 1'b0, 8'h3C, 8'hA5);
    start(t0);
    wait_idle("t1_write_done");
    chk("t1_cmd_count", 32'(cmd_log.size()), 2);
    chk("t1_addr_cmd", 32'(cmd_din(0)), 32'h03C);
    chk("t1_addr_cyc", 32'(cmd_cyc(0) - t0), 1);
    chk("t1_data_cmd", 32'(cmd_din(1)), 32'h1A5);
    chk("t1_data_cyc", 32'(cmd_cyc(1) - t0), 2);
    chk("t1_wack_cyc", 32'(ack_cyc(0) - t0), 3);
    chk("t1_wack_idx", 32'(ack_idx(0)), 0);
    push(0, 1'b1, 8'h3C, 8'h00);
    start(t0);
    wait_idle("t1_read_done");
    chk("t1_rack_cyc", 32'(ack_cyc(0) - t0), 32'(T1_RD_LAT));
    chk("t1_rdata", 32'(ack_rd(0)), 32'hA5);

    // Simultaneous writes after reset: requester 0 first, no interleaving.
    do_reset();
    push(0, 1'b0, 8'h10, 8'h11);
    push(1, 1'b0, 8'h20, 8'h22);
    start(t0);
    wait_idle("t2_done");
    chk("t2_cmd0", 32'(cmd_din(0)), 32'h010);
    chk("t2_cmd1", 32'(cmd_din(1)), 32'h111);
    chk("t2_cmd2", 32'(cmd_din(2)), 32'h020);
    chk("t2_cmd3", 32'(cmd_din(3)), 32'h122);
    chk("t2_first_idx", 32'(ack_idx(0)), 0);
    chk("t2_second_idx", 32'(ack_idx(1)), 1);
    chk("t2_regrant_in_ack", 32'(cmd_cyc(2) - ack_cyc(0)), 1);
    chk("t2_total_cyc", 32'(ack_cyc(1) - t0), 6);

    // Both requesters streaming reads: grants must alternate.
    push(0, 1'b1, 8'h10, 8'h00); push(0, 1'b1, 8'h3C, 8'h00); push(0, 1'b1, 8'h10, 8'h00);
    push(1, 1'b1, 8'h20, 8'h00); push(1, 1'b1, 8'h20, 8'h00); push(1, 1'b1, 8'h20, 8'h00);
    start(t0);
    wait_idle("t3_done");
    chk("t3_ack_count", 32'(ack_log.size()), 6);
    for (int k = 0; k < 6; k++) chk("t3_rr_order", 32'(ack_idx(k)), 32'(k % 2));
    chk("t3_rdata0", 32'(ack_rd(0)), 32'h11);
    chk("t3_rdata1", 32'(ack_rd(1)), 32'h22);
    chk("t3_rdata2", 32'(ack_rd(2)), 32'hA5);

    // Reset during the DATA cycle of a read; held request completes afterwards.
    push(0, 1'b1, 8'h3C, 8'h00);
    start(t0);
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    chk("t4_busy_before_rst", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t4_async_busy", 32'(busy), 0);
    chk("t4_async_din", 32'(ram_din), 0);
    chk("t4_async_rxv", 32'(ram_rx_valid), 0);
    chk("t4_async_ack", 32'(ack), 0);
    chk("t4_async_rdata", 32'(rdata), 0);
    @(posedge CLK); #2;
    rst_n = 1'b1;
    wait_idle("t4_done");
    chk("t4_ack_count", 32'(ack_log.size()), 1);
    chk("t4_ack_idx", 32'(ack_idx(0)), 0);
    chk("t4_rdata", 32'(ack_rd(0)), 32'hA5);
    chk("t4_cmd_count", 32'(cmd_log.size()), 3);

`ifdef RAM_ARB_ADDR_CACHE_EN
    // Address cache: a read of the last-sent address skips the address command.
    push(0, 1'b0, 8'h05, 8'h44);
    start(t0);
    wait_idle("t5_write_done");
    push(0, 1'b1, 8'h05, 8'h00);
    start(t0);
    wait_idle("t5_hit_done");
    chk("t5_hit_cmd_count", 32'(cmd_log.size()), 1);
    chk("t5_hit_cmd", 32'(cmd_din(0)), 32'h300);
    chk("t5_hit_ack_cyc", 32'(ack_cyc(0) - t0), 3);
    chk("t5_hit_rdata", 32'(ack_rd(0)), 32'h44);
    push(0, 1'b1, 8'h06, 8'h00);
    start(t0);
    wait_idle("t5_miss_done");
    chk("t5_miss_cmd", 32'(cmd_din(0)), 32'h206);
    chk("t5_miss_ack_cyc", 32'(ack_cyc(0) - t0), 4);
`endif

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_cmd_arbiter.md
# ram_cmd_arbiter

Round-robin controller that shares the single-port command RAM between several requesters. Each requester issues a whole read or write transaction. The block converts it into the RAM's 10-bit two-word command sequence (address command, then data command) and returns read data. Transactions are atomic: the RAM's single address register cannot be disturbed by another requester mid-transaction. The block sits between the requester-side logic and the RAM's `din`/`rx_valid`/`dout`/`tx_valid` port.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (≥2)
- `DATA_WIDTH`, 8, payload width; address width equals `DATA_WIDTH` because address and data share the command payload field
- `CMD_WIDTH`, `DATA_WIDTH+2`, RAM command word width

Ports:
- `CLK`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  `NUM_REQ`  per-requester transaction request; held with op/addr/wdata stable until the matching `ack` bit
- `op`  in  `NUM_REQ`  per requester: 1 = read, 0 = write
- `addr`  in  `NUM_REQ*DATA_WIDTH`  packed addresses; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- `wdata`  in  `NUM_REQ*DATA_WIDTH`  packed write data, same packing as `addr`
- `ack`  out  `NUM_REQ`  one-cycle completion pulse, one-hot or zero
- `rdata`  out  `DATA_WIDTH`  read data; valid only in the cycle a read's `ack` is high
- `busy`  out  1  high whenever state ≠ IDLE
- `ram_din`  out  `CMD_WIDTH`  command word to RAM: {opcode[1:0], payload}
- `ram_rx_valid`  out  1  command strobe to RAM
- `ram_dout`  in  `DATA_WIDTH`  RAM read data
- `ram_tx_valid`  in  1  RAM read-valid; sticky in the RAM, so sampled only in RWAIT

## Operation
- RAM opcodes:
  - 00 = write-address
  - 01 = write-data
  - 10 = read-address
  - 11 = read-data
- FSM states: IDLE, ADDR, DATA, RWAIT.
- **IDLE:** arbitrate among `req` bits, masking any bit whose `ack` is currently high. If there is a winner:
  - latch grant index, op, addr and wdata;
  - register `ram_din` = {op?10:00, addr}, `ram_rx_valid`=1;
  - go to ADDR.
- **ADDR:** register `ram_din` = {op?11:01, op?0:wdata}, `ram_rx_valid`=1; go to DATA.
- **DATA:** `ram_rx_valid`<=0.
  - Write: `ack[grant]`<=1; go to IDLE.
  - Read: go to RWAIT.
- **RWAIT:** `rdata`<=`ram_dout`, `ack[grant]`<=1; go to IDLE.
  - `ram_tx_valid` low here is a protocol violation: flag it with an assertion, still complete.
- **Round-robin:** pointer holds the last granted index. Priority starts at pointer+1 and wraps modulo `NUM_REQ`. The pointer updates only on grant.
- Requests arriving mid-transaction wait; they are never dropped.
- `ram_din` and `ram_rx_valid` are registered outputs. `ram_din` holds its last value when `ram_rx_valid`=0.

## Timing
- **Reset values:**
  - `ack`=0, `rdata`=0, `busy`=0, `ram_din`=0, `ram_rx_valid`=0
  - state IDLE, pointer=`NUM_REQ-1` (requester 0 wins first)
- **Latency** (T0 = first IDLE cycle with `req` high):
  - address command visible in T1, data command in T2;
  - write `ack` in T3;
  - read `ram_tx_valid` in T3, `ack`+`rdata` in T4.
- **Throughput:**
  - the next grant is decided in the ack cycle, so back-to-back writes from different requesters take 3 cycles each;
  - the same requester cannot be re-granted in its own ack cycle.
- **Reset mid-transaction:** the transaction is abandoned, no `ack` is issued, and requesters must reissue. A partially issued RAM write leaves the RAM address register modified, which is acceptable.
- A `req` dropped before `ack` is a requester protocol error and is not supported.

## Configuration
- `RAM_ARB_ADDR_CACHE_EN` defined:
  - the block tracks the last address sent to the RAM (valid bit cleared on reset);
  - if the granted address equals it, IDLE skips ADDR and issues the data command directly;
  - write `ack` moves to T2 and read `ack` to T3.
  - This is valid because the RAM keeps one address register for both reads and writes.
- Undefined: every transaction issues both commands.

## Structure
- Package `ram_arb_pkg` holds:
  - opcode constants `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`;
  - FSM state encoding;
  - default widths.
- One sub-module, `rr_arbiter`: combinational masked round-robin grant from `req`, mask and pointer, plus the registered pointer update on the `grant_en` strobe.

## Test plan
- Single write, req0: addr=0x3C, wdata=0xA5 -> `ram_din`=0x03C in T1, 0x1A5 in T2, `ack`=01 in T3; a later read of 0x3C returns `rdata`=0xA5 with `ack`=01 in T4.
- req0 and req1 both asserted after reset with writes to 0x10/0x20 -> req0 served first, req1 granted in req0's ack cycle; RAM sees command sequence 0x010, 0x1xx, 0x020, 0x1xx, never interleaved.
- Both requesters held continuously issuing reads -> grants alternate 0,1,0,1; no requester starved.
- `rst_n` pulsed low during the DATA cycle of a read -> all outputs 0 immediately, no `ack`; after release, the held req completes normally.
- With `RAM_ARB_ADDR_CACHE_EN`: write 0x44 to addr 0x05, then read addr 0x05 -> the read has no address command, `ack` arrives 3 cycles after the request, `rdata`=0x44; a read of 0x06 issues the address command.
